// File: rtl/mha_pkg.sv
// Shared types and helpers for the multi-matmul wrapper and its downstream consumers.
package mha_pkg;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} collector_state_t;

    // Number of SLICE_W-wide slices that make up one wrapper result vector.
    function automatic int slices_per_vec(input int num_cores_a,
                                          input int num_cores_b,
                                          input int total_modules);
        return num_cores_a * num_cores_b * total_modules;
    endfunction

endpackage

// File: rtl/matmul_out_collector.sv
// Captures a batch of wrapper result vectors on the rising edge of acc_done_wrap
// and drains them slice by slice as an addressed write stream, so the wrapper
// can start its next accumulation while results are still leaving.
module matmul_out_collector
    import mha_pkg::*;
#(
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 4,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 2,
    parameter int TOTAL_INPUT_W = 2,
    parameter int ADDR_WIDTH    = 10,
    localparam int SLICE_W = WIDTH_OUT * CHUNK_SIZE,
    localparam int SLICES  = slices_per_vec(NUM_CORES_A, NUM_CORES_B, TOTAL_MODULES),
    localparam int VEC_W   = SLICE_W * SLICES,
    localparam int BEATS   = TOTAL_INPUT_W * SLICES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_done_wrap,
    input  logic [VEC_W-1:0]      in_result [TOTAL_INPUT_W],
    input  logic                  addr_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SLICE_W-1:0]    out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  batch_done,
    output logic                  overflow
);

    localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int HOLD_W = TOTAL_INPUT_W * VEC_W;
    localparam int SW     = (HOLD_W > 1) ? $clog2(HOLD_W) : 1;

    collector_state_t      state_q, state_d;
    logic                  acc_q;
    logic [KW-1:0]         k_q, k_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [HOLD_W-1:0]     in_flat;
    logic [SW-1:0]         sel_lsb;
    logic                  capture, xfer, last_beat;

    // Flatten the batch so beat k sits at bits [k*SLICE_W +: SLICE_W]
    // (vector index outer, slice index inner).
    always_comb begin
        in_flat = '0;
        for (int i = 0; i < TOTAL_INPUT_W; i++) begin
            in_flat[i*VEC_W +: VEC_W] = in_result[i];
        end
    end

    assign capture   = acc_done_wrap & ~acc_q;
    assign last_beat = (k_q == KW'(BEATS - 1));
    assign xfer      = (state_q == STREAM) & out_ready;
    assign sel_lsb   = SW'(k_q) * SW'(SLICE_W);

    // Next-state logic: capture, beat advance, base update and overflow detection.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                // Clear lands before a same-cycle capture, so that batch starts at 0.
                if (addr_clr) base_d = '0;
                if (capture) begin
                    hold_d  = in_flat;
                    k_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer && last_beat) begin
                    base_d = base_q + ADDR_WIDTH'(BEATS);
                    done_d = 1'b1;
                    k_d    = '0;
                    // A capture on the final transfer chains the next batch with no bubble.
                    if (capture) hold_d  = in_flat;
                    else         state_d = IDLE;
                end else begin
                    if (xfer)    k_d   = k_q + KW'(1);
                    // Holding register is still draining: drop the batch and flag it.
                    if (capture) ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            k_q     <= '0;
            base_q  <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_done_wrap;
            k_q     <= k_d;
            base_q  <= base_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode registered state only; out_ready never reaches them.
    assign busy       = (state_q == STREAM);
    assign out_valid  = busy;
    assign out_last   = busy & last_beat;
    assign out_addr   = busy ? base_q + ADDR_WIDTH'(k_q) : '0;
    assign out_data   = busy ? hold_q[sel_lsb +: SLICE_W] : '0;
    assign batch_done = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_matmul_out_collector.sv
// Randomized bench for matmul_out_collector with a queue-based reference model.
// A second instance with a 4-bit address shadows the main one to cover wrap.
module tb_matmul_out_collector;

    localparam int WIDTH_OUT = 16, CHUNK_SIZE = 4, NUM_CORES_A = 4, NUM_CORES_B = 1;
    localparam int TOTAL_MODULES = 2, TOTAL_INPUT_W = 2, ADDR_WIDTH = 10;
    localparam int SLICE_W = WIDTH_OUT * CHUNK_SIZE;
    localparam int SLICES  = NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES;
    localparam int VEC_W   = SLICE_W * SLICES;
    localparam int BEATS   = TOTAL_INPUT_W * SLICES;

    logic clk = 1'b0;
    logic rst_n, acc_done_wrap, addr_clr, out_ready;
    logic [VEC_W-1:0] in_result [TOTAL_INPUT_W];
    logic out_valid, out_last, busy, batch_done, overflow;
    logic [SLICE_W-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic out_valid4, out_last4, busy4, batch_done4, overflow4;
    logic [SLICE_W-1:0] out_data4;
    logic [3:0] out_addr4;

    always #5 clk = ~clk;

    matmul_out_collector dut (
        .clk(clk), .rst_n(rst_n), .acc_done_wrap(acc_done_wrap), .in_result(in_result),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .batch_done(batch_done),
        .overflow(overflow));

    matmul_out_collector #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .acc_done_wrap(acc_done_wrap), .in_result(in_result),
        .addr_clr(addr_clr), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_addr(out_addr4), .out_last(out_last4), .busy(busy4), .batch_done(batch_done4),
        .overflow(overflow4));

    int n_pass = 0, n_total = 0;
    int cyc = 0, first_xfer_cyc = 0, last_xfer_cyc = 0, done_cyc = 0, n_done = 0;
    int m_base = 0;

    // Expected and observed beat streams.
    logic [ADDR_WIDTH-1:0] exp_addr[$], obs_addr[$];
    logic [3:0]            exp_addr4[$], obs_addr4[$];
    logic [SLICE_W-1:0]    exp_data[$], obs_data[$];
    logic                  exp_last[$], obs_last[$];

    // Output snapshot of the most recent step.
    logic s_valid, s_last, s_busy, s_done, s_ovf;
    logic [SLICE_W-1:0] s_data;
    logic [ADDR_WIDTH-1:0] s_addr;

    // One cycle: drive ready at the falling edge, snapshot outputs, log transfers.
    task automatic step(input logic rdy);
        @(negedge clk);
        out_ready = rdy;
        cyc++;
        s_valid = out_valid; s_last = out_last; s_busy = busy; s_done = batch_done;
        s_ovf = overflow; s_data = out_data; s_addr = out_addr;
        if (out_valid && rdy) begin
            if (obs_addr.size() == 0) first_xfer_cyc = cyc;
            obs_addr.push_back(out_addr);
            obs_addr4.push_back(out_addr4);
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
            last_xfer_cyc = cyc;
        end
        if (batch_done) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic rand_result();
        for (int i = 0; i < TOTAL_INPUT_W; i++)
            for (int w = 0; w < VEC_W / 32; w++) in_result[i][w*32 +: 32] = $urandom;
    endtask

    // Reference model: a capture produces BEATS writes at consecutive addresses,
    // vector-major, slice 0 taken from the low bits of each vector.
    task automatic model_capture();
        logic [VEC_W-1:0] v;
        for (int k = 0; k < BEATS; k++) begin
            v = in_result[k / SLICES];
            exp_data.push_back(SLICE_W'(v >> ((k % SLICES) * SLICE_W)));
            exp_addr.push_back(ADDR_WIDTH'((m_base + k) % (1 << ADDR_WIDTH)));
            exp_addr4.push_back(4'((m_base + k) % 16));
            exp_last.push_back(k == BEATS - 1);
        end
        m_base = (m_base + BEATS) % (1 << ADDR_WIDTH);
    endtask

    task automatic clear_q();
        exp_addr.delete(); exp_addr4.delete(); exp_data.delete(); exp_last.delete();
        obs_addr.delete(); obs_addr4.delete(); obs_data.delete(); obs_last.delete();
        n_done = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; acc_done_wrap = 1'b0; addr_clr = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < TOTAL_INPUT_W; i++) in_result[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        n_total++; if (s_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", s_valid); else n_pass++;
        n_total++; if (s_last !== 1'b0) $display("FAIL reset_last got %b want 0", s_last); else n_pass++;
        n_total++; if (s_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", s_busy); else n_pass++;
        n_total++; if (s_done !== 1'b0) $display("FAIL reset_done got %b want 0", s_done); else n_pass++;
        n_total++; if (s_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", s_ovf); else n_pass++;
        n_total++; if (s_data !== '0) $display("FAIL reset_data got %h want 0", s_data); else n_pass++;
        n_total++; if (s_addr !== '0) $display("FAIL reset_addr got %h want 0", s_addr); else n_pass++;
        clear_q();
    endtask

    task automatic test_basic();
        for (int i = 0; i < TOTAL_INPUT_W; i++)
            for (int s = 0; s < SLICES; s++) in_result[i][s*SLICE_W +: SLICE_W] = SLICE_W'(i * 256 + s);
        model_capture();
        acc_done_wrap = 1'b1;
        step(1'b1);
        acc_done_wrap = 1'b0;
        n_total++; if (s_valid !== 1'b1) $display("FAIL basic_latency valid got %b want 1", s_valid); else n_pass++;
        repeat (20) step(1'b1);
        n_total++; if (obs_addr.size() != BEATS) $display("FAIL basic_count got %0d want %0d", obs_addr.size(), BEATS); else n_pass++;
        foreach (exp_addr[k]) if (k < obs_addr.size()) begin
            n_total++;
            if (obs_addr[k] !== exp_addr[k] || obs_addr4[k] !== exp_addr4[k] || obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k])
                $display("FAIL basic_beat%0d got a=%h a4=%h d=%h l=%b want a=%h a4=%h d=%h l=%b", k, obs_addr[k], obs_addr4[k], obs_data[k], obs_last[k], exp_addr[k], exp_addr4[k], exp_data[k], exp_last[k]);
            else n_pass++;
        end
        n_total++; if (last_xfer_cyc - first_xfer_cyc != BEATS - 1) $display("FAIL basic_span got %0d want %0d", last_xfer_cyc - first_xfer_cyc + 1, BEATS); else n_pass++;
        n_total++; if (n_done != 1 || done_cyc != last_xfer_cyc + 1) $display("FAIL basic_done got n=%0d at %0d want n=1 at %0d", n_done, done_cyc, last_xfer_cyc + 1); else n_pass++;
        n_total++; if (s_busy !== 1'b0) $display("FAIL basic_idle busy got %b want 0", s_busy); else n_pass++;
        clear_q();
    endtask

    task automatic test_second_batch();
        rand_result();
        model_capture();
        acc_done_wrap = 1'b1;
        step(1'b1);
        acc_done_wrap = 1'b0;
        repeat (20) step(1'b1);
        n_total++; if (obs_addr.size() != BEATS) $display("FAIL second_count got %0d want %0d", obs_addr.size(), BEATS); else n_pass++;
        foreach (exp_addr[k]) if (k < obs_addr.size()) begin
            n_total++;
            if (obs_addr[k] !== exp_addr[k] || obs_addr4[k] !== exp_addr4[k] || obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k])
                $display("FAIL second_beat%0d got a=%h a4=%h d=%h l=%b want a=%h a4=%h d=%h l=%b", k, obs_addr[k], obs_addr4[k], obs_data[k], obs_last[k], exp_addr[k], exp_addr4[k], exp_data[k], exp_last[k]);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        logic rdy, p_stall;
        logic [SLICE_W-1:0] p_data;
        logic [ADDR_WIDTH-1:0] p_addr;
        rand_result();
        model_capture();
        acc_done_wrap = 1'b1;
        p_stall = 1'b0;
        for (int j = 0; j < 80; j++) begin
            rdy = pat[j % 4];
            step(rdy);
            acc_done_wrap = 1'b0;
            if (p_stall && s_valid) begin
                n_total++;
                if (s_data !== p_data || s_addr !== p_addr)
                    $display("FAIL bp_stable cyc%0d got a=%h d=%h want a=%h d=%h", cyc, s_addr, s_data, p_addr, p_data);
                else n_pass++;
            end
            p_stall = s_valid && !rdy;
            p_data = s_data; p_addr = s_addr;
        end
        n_total++; if (obs_addr.size() != BEATS) $display("FAIL bp_count got %0d want %0d", obs_addr.size(), BEATS); else n_pass++;
        foreach (exp_addr[k]) if (k < obs_addr.size()) begin
            n_total++;
            if (obs_addr[k] !== exp_addr[k] || obs_addr4[k] !== exp_addr4[k] || obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k])
                $display("FAIL bp_beat%0d got a=%h a4=%h d=%h l=%b want a=%h a4=%h d=%h l=%b", k, obs_addr[k], obs_addr4[k], obs_data[k], obs_last[k], exp_addr[k], exp_addr4[k], exp_data[k], exp_last[k]);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        bit found = 0;
        rand_result();
        model_capture();
        acc_done_wrap = 1'b1;
        step(1'b1);
        acc_done_wrap = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            step(1'b1);
            if (s_valid && s_last) begin
                rand_result();
                model_capture();
                acc_done_wrap = 1'b1;
                found = 1;
            end
        end
        n_total++; if (!found) $display("FAIL b2b_timeout got no last beat want one within 40 cycles"); else n_pass++;
        step(1'b1);
        acc_done_wrap = 1'b0;
        n_total++; if (s_busy !== 1'b1 || s_valid !== 1'b1) $display("FAIL b2b_bubble got busy=%b valid=%b want 1 1", s_busy, s_valid); else n_pass++;
        n_total++; if (s_addr !== exp_addr[BEATS]) $display("FAIL b2b_addr got %h want %h", s_addr, exp_addr[BEATS]); else n_pass++;
        n_total++; if (s_done !== 1'b1) $display("FAIL b2b_done got %b want 1", s_done); else n_pass++;
        repeat (20) step(1'b1);
        n_total++; if (s_ovf !== 1'b0) $display("FAIL b2b_ovf got %b want 0", s_ovf); else n_pass++;
        n_total++; if (obs_addr.size() != 2 * BEATS || n_done != 2) $display("FAIL b2b_count got %0d/%0d want %0d/2", obs_addr.size(), n_done, 2 * BEATS); else n_pass++;
        foreach (exp_addr[k]) if (k < obs_addr.size()) begin
            n_total++;
            if (obs_addr[k] !== exp_addr[k] || obs_addr4[k] !== exp_addr4[k] || obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k])
                $display("FAIL b2b_beat%0d got a=%h a4=%h d=%h l=%b want a=%h a4=%h d=%h l=%b", k, obs_addr[k], obs_addr4[k], obs_data[k], obs_last[k], exp_addr[k], exp_addr4[k], exp_data[k], exp_last[k]);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_overflow();
        bit raised = 0;
        rand_result();
        model_capture();
        acc_done_wrap = 1'b1;
        step(1'($urandom_range(0, 1)));
        acc_done_wrap = 1'b0;
        for (int j = 0; j < 100 && obs_addr.size() < BEATS; j++) begin
            step(1'($urandom_range(0, 1)));
            if (raised) acc_done_wrap = 1'b0;
            else if (obs_addr.size() == 5) begin
                n_total++; if (s_ovf !== 1'b0) $display("FAIL ovf_pre got %b want 0", s_ovf); else n_pass++;
                rand_result();
                acc_done_wrap = 1'b1;
                raised = 1;
            end
        end
        repeat (4) step(1'b1);
        n_total++; if (s_ovf !== 1'b1) $display("FAIL ovf_sticky got %b want 1", s_ovf); else n_pass++;
        n_total++; if (obs_addr.size() != BEATS) $display("FAIL ovf_count got %0d want %0d", obs_addr.size(), BEATS); else n_pass++;
        foreach (exp_addr[k]) if (k < obs_addr.size()) begin
            n_total++;
            if (obs_addr[k] !== exp_addr[k] || obs_addr4[k] !== exp_addr4[k] || obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k])
                $display("FAIL ovf_beat%0d got a=%h a4=%h d=%h l=%b want a=%h a4=%h d=%h l=%b", k, obs_addr[k], obs_addr4[k], obs_data[k], obs_last[k], exp_addr[k], exp_addr4[k], exp_data[k], exp_last[k]);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        rand_result();
        model_capture();
        acc_done_wrap = 1'b1;
        step(1'b1);
        acc_done_wrap = 1'b0;
        for (int j = 0; j < 20 && obs_addr.size() < 8; j++) step(1'b1);
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || batch_done !== 1'b0 || overflow !== 1'b0 || out_data !== '0 || out_addr !== '0)
            $display("FAIL midreset_outputs got v=%b l=%b b=%b d=%b o=%b data=%h a=%h want all 0", out_valid, out_last, busy, batch_done, overflow, out_data, out_addr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        m_base = 0;
        clear_q();
        rand_result();
        model_capture();
        acc_done_wrap = 1'b1;
        repeat (40) step(1'b1);
        acc_done_wrap = 1'b0;
        repeat (4) step(1'b1);
        n_total++; if (obs_addr.size() != BEATS) $display("FAIL level_count got %0d want %0d", obs_addr.size(), BEATS); else n_pass++;
        foreach (exp_addr[k]) if (k < obs_addr.size()) begin
            n_total++;
            if (obs_addr[k] !== exp_addr[k] || obs_addr4[k] !== exp_addr4[k] || obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k])
                $display("FAIL level_beat%0d got a=%h a4=%h d=%h l=%b want a=%h a4=%h d=%h l=%b", k, obs_addr[k], obs_addr4[k], obs_data[k], obs_last[k], exp_addr[k], exp_addr4[k], exp_data[k], exp_last[k]);
            else n_pass++;
        end
        clear_q();
    endtask

    task automatic test_addr_clr();
        // Clear asserted mid-stream must be ignored.
        rand_result();
        model_capture();
        acc_done_wrap = 1'b1;
        step(1'b1);
        acc_done_wrap = 1'b0;
        addr_clr = 1'b1;
        repeat (4) step(1'b1);
        addr_clr = 1'b0;
        repeat (16) step(1'b1);
        // Clear together with a capture in IDLE: batch starts at 0.
        addr_clr = 1'b1;
        rand_result();
        m_base = 0;
        model_capture();
        acc_done_wrap = 1'b1;
        step(1'b1);
        addr_clr = 1'b0;
        acc_done_wrap = 1'b0;
        repeat (20) step(1'b1);
        n_total++; if (obs_addr.size() != 2 * BEATS) $display("FAIL clr_count got %0d want %0d", obs_addr.size(), 2 * BEATS); else n_pass++;
        foreach (exp_addr[k]) if (k < obs_addr.size()) begin
            n_total++;
            if (obs_addr[k] !== exp_addr[k] || obs_addr4[k] !== exp_addr4[k] || obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k])
                $display("FAIL clr_beat%0d got a=%h a4=%h d=%h l=%b want a=%h a4=%h d=%h l=%b", k, obs_addr[k], obs_addr4[k], obs_data[k], obs_last[k], exp_addr[k], exp_addr4[k], exp_data[k], exp_last[k]);
            else n_pass++;
        end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_batch();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_addr_clr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matmul_out_collector.md
# matmul_out_collector

Downstream stage of the multi-matmul wrapper: captures all `TOTAL_INPUT_W` wide result vectors when the wrapper's accumulation completes, then serializes them slice by slice into a BRAM-style write stream with a running address. This frees the wrapper to start the next accumulation while results drain. It also flags any result batch that arrives before the previous one has drained.

## Interface
- `WIDTH_OUT`, 16: bits per output element.
- `CHUNK_SIZE`, 4: elements per slice.
- `NUM_CORES_A`, 4: A-side cores; a slice-count factor.
- `NUM_CORES_B`, 1: B-side cores; a slice-count factor.
- `TOTAL_MODULES`, 2: matmul modules per instance; a slice-count factor.
- `TOTAL_INPUT_W`, 2: number of result vectors per batch.
- `ADDR_WIDTH`, 10: write-address width.
- Derived: `SLICE_W = WIDTH_OUT*CHUNK_SIZE`.
- Derived: `SLICES = NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES`.
- Derived: `VEC_W = SLICE_W*SLICES`.
- Derived: `BEATS = TOTAL_INPUT_W*SLICES`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `acc_done_wrap`  in  1  level from the wrapper; a capture is triggered on its rising edge.
- `in_result [TOTAL_INPUT_W]`  in  `VEC_W` each  result vectors from the wrapper.
- `addr_clr`  in  1  sets the base address to 0; honoured only in IDLE.
- `out_valid`  out  1  write beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_data`  out  `SLICE_W`  current slice.
- `out_addr`  out  `ADDR_WIDTH`  write address of the current beat.
- `out_last`  out  1  final beat of the batch.
- `busy`  out  1  high when not IDLE.
- `batch_done`  out  1  one-cycle pulse after the last beat is accepted.
- `overflow`  out  1  sticky error flag; cleared only by reset.

## Operation
- Edge detect: a registered copy `acc_d` of `acc_done_wrap` (reset 0). The capture event is `acc_done_wrap & ~acc_d`.
- FSM states are IDLE and STREAM.
- IDLE → STREAM on a capture event:
  - Latch all `in_result` vectors into a holding register.
  - Set beat index to 0.
- In STREAM, `out_valid` is 1.
- Beat `k` maps to instance `k / SLICES` and slice `k % SLICES`. Slice 0 is bits `[SLICE_W-1:0]`, so the instance index is outer and the slice index is inner.
- `out_addr` = base + k, modulo 2^`ADDR_WIDTH`.
- Handshake: a beat transfers when `out_valid & out_ready`.
  - On transfer, k increments.
  - While not accepted, `out_data`, `out_addr` and `out_last` hold stable.
- `out_last` = (k == `BEATS`-1) while in STREAM.
- When the last beat transfers:
  - base += `BEATS`, wrapping modulo 2^`ADDR_WIDTH`.
  - `batch_done` pulses on the next cycle.
  - The FSM returns to IDLE, unless a capture event occurs in the same cycle. In that case the new batch is latched, k = 0, and the FSM stays in STREAM, giving back-to-back batches with no bubble.
- A capture event in STREAM without a last-beat transfer is dropped. The holding register is untouched and `overflow` is set to 1.
- `addr_clr` in IDLE sets base to 0 on the next cycle. If a capture event occurs in the same cycle, the clear takes effect first, so the new batch starts at address 0. `addr_clr` outside IDLE is ignored.
- No arithmetic is performed on the data; slices pass through bit-exact.

## Timing
- Reset values:
  - FSM = IDLE; k = 0; base = 0; `acc_d` = 0.
  - `out_valid` = 0; `out_last` = 0; `busy` = 0; `batch_done` = 0; `overflow` = 0.
  - `out_data` = 0; `out_addr` = 0.
- Latency: the rising edge of `acc_done_wrap` is sampled at edge N, and `out_valid` is 1 from cycle N+1.
- With `out_ready` held high, one batch occupies exactly `BEATS` cycles.
- `batch_done` is asserted in the cycle after the last transfer, for exactly 1 cycle.
- Outputs are registered, with no combinational path from `out_ready` to `out_valid` or `out_data`. `out_last` may be decoded from registered k.
- An asynchronous reset asserted mid-stream aborts the batch immediately. The base address returns to 0.
- An `acc_done_wrap` held high for many cycles produces one capture only. A new capture requires it to fall and rise again.

## Structure
- Shared package `mha_pkg` holds:
  - `typedef enum logic {IDLE, STREAM} collector_state_t`.
  - A function `slices_per_vec(NUM_CORES_A, NUM_CORES_B, TOTAL_MODULES)` that is reused by the wrapper's consumers.
- Single module; no sub-module is needed. Slice selection is an indexed part-select on the holding register.

## Test plan
1. Defaults (`SLICES`=8, `BEATS`=16, `SLICE_W`=64), with `in_result[0]` slice s = 64'h0 + s and `in_result[1]` slice s = 64'h100 + s. With `out_ready`=1 and one pulse: 16 beats at addresses 0..15, data in order 0..7 then 0x100..0x107, `out_last` on address 15, and `batch_done` the cycle after.
2. Backpressure: toggle `out_ready` 1,0,0,1 repeatedly. Data and address are stable during stalls, no beat is lost or duplicated, and the total is 16 transfers.
3. Second batch: after the first batch, the next pulse writes addresses 16..31. With `ADDR_WIDTH`=4, the second batch wraps to addresses 0..15.
4. Back-to-back: a capture event coinciding with the last-beat transfer. The next cycle shows beat 0 of the new batch, `busy` stays 1, and `overflow` stays 0.
5. Overflow: a capture event at beat 5 of a batch. `overflow` becomes 1 and stays 1, and the remaining beats carry the original data.
6. Reset and `acc_done_wrap` level: assert `rst_n`=0 at beat 7, and all outputs return to their reset values. Then hold `acc_done_wrap` high for 40 cycles: exactly 16 beats result, not 32.
